// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the writeback source tag.
package cpu_pkg;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 2 ** AW;

  // Encodings double as requester indices inside the writeback arbiter.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_t;
endpackage

// File: rtl/wb_unit_rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 is the ALU and bit 1 is memory.
// The last-winner state moves only when both requesters collide.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_t last;

  // NOTE: every output of an always_comb block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == SRC_MEM) ? 2'b01 : 2'b10;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= SRC_MEM;
    end else if (req == 2'b11) begin
      last <= gnt[0] ? SRC_ALU : SRC_MEM;
    end
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: arbitrates ALU and memory results onto the register-file write port
// and tracks which destinations still have a long-latency result outstanding.
module wb_unit
  import cpu_pkg::*;
#(
  parameter int AW   = cpu_pkg::AW,
  parameter int DW   = cpu_pkg::DW,
  parameter int NREG = cpu_pkg::NREG
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [DW-1:0]   alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [DW-1:0]   mem_data,
  output logic [AW-1:0]   rd,
  output logic            we,
  output logic [DW-1:0]   wdata,
  output logic [NREG-1:0] busy,
  output logic            err
);

  logic [1:0]      gnt;
  logic            xfer;
  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;
  wb_src_t         sel_src;
  wb_src_t         src;
  logic [NREG-1:0] busy_nxt;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({mem_valid, alu_valid}),
    .gnt   (gnt)
  );

  assign alu_ready = gnt[SRC_ALU];
  assign mem_ready = gnt[SRC_MEM];
  assign xfer      = alu_ready | mem_ready;
  assign iss_ready = !busy[iss_rd];

  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    sel_src  = SRC_ALU;
    if (mem_ready) begin
      sel_rd   = mem_rd;
      sel_data = mem_data;
      sel_src  = SRC_MEM;
    end
  end

  // Clear lands on the commit edge of a memory write, so readers never see a
  // cleared bit before the data is in the register file.
  always_comb begin
    busy_nxt = busy;
    if (we && src == SRC_MEM) begin
      busy_nxt[rd] = 1'b0;
    end
    if (iss_valid && iss_ready && iss_rd != '0) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd    <= '0;
      we    <= 1'b0;
      wdata <= '0;
      src   <= SRC_ALU;
      busy  <= '0;
      err   <= 1'b0;
    end else begin
      we   <= xfer && (sel_rd != '0);
      busy <= busy_nxt;
      if (xfer) begin
        rd    <= sel_rd;
        wdata <= sel_data;
        src   <= sel_src;
      end
      if (mem_ready && mem_rd != '0 && !busy[mem_rd]) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: a directed vector table plus reset/conflict sequences.
module tb_wb_unit;
  import cpu_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            iss_ready;
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [DW-1:0]   alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [AW-1:0]   mem_rd;
  logic [DW-1:0]   mem_data;
  logic [AW-1:0]   rd;
  logic            we;
  logic [DW-1:0]   wdata;
  logic [NREG-1:0] busy;
  logic            err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_unit dut (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .rd        (rd),
    .we        (we),
    .wdata     (wdata),
    .busy      (busy),
    .err       (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          av;
    logic [4:0]    ard;
    logic [31:0]   ad;
    logic          mv;
    logic [4:0]    mrd;
    logic [31:0]   md;
    logic          iv;
    logic [4:0]    ird;
    logic          x_ar;
    logic          x_mr;
    logic          x_ir;
    logic          x_we;
    logic [4:0]    x_rd;
    logic [31:0]   x_wd;
    logic [31:0]   x_busy;
    logic          x_err;
  } vec_t;

  vec_t vecs[15];

  task automatic drive(input vec_t v);
    alu_valid = v.av;  alu_rd = v.ard;  alu_data = v.ad;
    mem_valid = v.mv;  mem_rd = v.mrd;  mem_data = v.md;
    iss_valid = v.iv;  iss_rd = v.ird;
  endtask

  initial begin
    // Comb expectations are checked before the edge, registered ones #1 after it.
    //            av ard ad            mv mrd md         iv ird ar mr ir we rd wd            busy          err
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 32'h0,     0, 0,  1, 0, 1, 1, 5, 32'hDEADBEEF, 32'h0,        0};
    vecs[1]  = '{0, 0, 32'h0,        0, 0, 32'h0,     0, 0,  0, 0, 1, 0, 5, 32'hDEADBEEF, 32'h0,        0};
    vecs[2]  = '{1, 0, 32'h1234,     0, 0, 32'h0,     1, 0,  1, 0, 1, 0, 0, 32'h1234,     32'h0,        0};
    vecs[3]  = '{0, 0, 32'h0,        0, 0, 32'h0,     1, 7,  0, 0, 1, 0, 0, 32'h1234,     32'h80,       0};
    vecs[4]  = '{0, 0, 32'h0,        0, 0, 32'h0,     1, 2,  0, 0, 1, 0, 0, 32'h1234,     32'h84,       0};
    vecs[5]  = '{0, 0, 32'h0,        0, 0, 32'h0,     1, 7,  0, 0, 0, 0, 0, 32'h1234,     32'h84,       0};
    vecs[6]  = '{0, 0, 32'h0,        1, 7, 32'h55,    0, 0,  0, 1, 1, 1, 7, 32'h55,       32'h84,       0};
    vecs[7]  = '{0, 0, 32'h0,        0, 0, 32'h0,     0, 0,  0, 0, 1, 0, 7, 32'h55,       32'h04,       0};
    vecs[8]  = '{1, 1, 32'hA1,       1, 2, 32'hB2,    1, 3,  1, 0, 1, 1, 1, 32'hA1,       32'h0C,       0};
    vecs[9]  = '{1, 1, 32'hA2,       1, 2, 32'hB2,    0, 0,  0, 1, 1, 1, 2, 32'hB2,       32'h0C,       0};
    vecs[10] = '{1, 1, 32'hA2,       1, 3, 32'hB3,    0, 0,  1, 0, 1, 1, 1, 32'hA2,       32'h08,       0};
    vecs[11] = '{1, 1, 32'hA3,       1, 3, 32'hB3,    0, 0,  0, 1, 1, 1, 3, 32'hB3,       32'h08,       0};
    vecs[12] = '{0, 0, 32'h0,        0, 0, 32'h0,     0, 0,  0, 0, 1, 0, 3, 32'hB3,       32'h0,        0};
    vecs[13] = '{0, 0, 32'h0,        1, 9, 32'h99,    0, 0,  0, 1, 1, 1, 9, 32'h99,       32'h0,        1};
    vecs[14] = '{0, 0, 32'h0,        0, 0, 32'h0,     0, 0,  0, 0, 1, 0, 9, 32'h99,       32'h0,        1};

    reset = 1'b0;
    drive('{default: '0});
    repeat (2) @(negedge clk);
    check("reset_we", {63'd0, we}, 64'd0);
    check("reset_busy", {32'd0, busy}, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_alu_ready", i), {63'd0, alu_ready}, {63'd0, vecs[i].x_ar});
      check($sformatf("v%0d_mem_ready", i), {63'd0, mem_ready}, {63'd0, vecs[i].x_mr});
      check($sformatf("v%0d_iss_ready", i), {63'd0, iss_ready}, {63'd0, vecs[i].x_ir});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_we", i),    {63'd0, we},    {63'd0, vecs[i].x_we});
      check($sformatf("v%0d_rd", i),    {59'd0, rd},    {59'd0, vecs[i].x_rd});
      check($sformatf("v%0d_wdata", i), {32'd0, wdata}, {32'd0, vecs[i].x_wd});
      check($sformatf("v%0d_busy", i),  {32'd0, busy},  {32'd0, vecs[i].x_busy});
      check($sformatf("v%0d_err", i),   {63'd0, err},   {63'd0, vecs[i].x_err});
      @(negedge clk);
    end

    // Reset mid-operation with every input active: everything returns to zero,
    // including the sticky err left set by the table above.
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
    mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h88;
    iss_valid = 1'b1; iss_rd = 5'd4;
    #2 reset = 1'b0;
    #1;
    check("rst_async_err", {63'd0, err}, 64'd0);
    check("rst_async_we", {63'd0, we}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_rd", {59'd0, rd}, 64'd0);
    check("rst_hold_wdata", {32'd0, wdata}, 64'd0);
    check("rst_hold_busy", {32'd0, busy}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst_we", {63'd0, we}, 64'd0);
    check("post_rst_busy", {32'd0, busy}, 64'd0);
    check("first_conflict_alu", {63'd0, alu_ready}, 64'd1);
    check("first_conflict_mem", {63'd0, mem_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("pr0_we", {63'd0, we}, 64'd1);
    check("pr0_rd", {59'd0, rd}, 64'd6);
    check("pr0_wdata", {32'd0, wdata}, 64'h66);
    check("pr0_busy", {32'd0, busy}, 64'h10);
    @(negedge clk);
    // Memory wins the next conflict; rd 8 is not pending, so err rises.
    check("pr1_mem_ready", {63'd0, mem_ready}, 64'd1);
    check("pr1_iss_ready", {63'd0, iss_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("pr1_rd", {59'd0, rd}, 64'd8);
    check("pr1_wdata", {32'd0, wdata}, 64'h88);
    check("pr1_err", {63'd0, err}, 64'd1);
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pr2_we", {63'd0, we}, 64'd0);
    check("pr2_err_sticky", {63'd0, err}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
